debounce_edge: RTL and testbench

Input conditioning stage that sits directly upstream of the team's async-reset register stages. It takes a raw asynchronous level (button, strap, external status line), synchronizes it, rejects glitches shorter than a programmable number of cycles, and produces a clean registered level, single-cycle rise/fall strobes and a saturating rising-edge event count. Downstream flops consume `level` or the strobes as a clean `d`.

---
 rtl/debounce_edge.sv | 130 +++++++++++++
 tb/tb_debounce_edge.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_edge.sv
// debounce_edge: synchronizes a raw asynchronous level, qualifies changes over
// DEBOUNCE_CYCLES consecutive samples, and produces a clean registered level,
// single-cycle rise/fall strobes and a saturating count of rising edges.
module debounce_edge #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             en,
  input  logic             clr_cnt,
  output logic             level,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] event_cnt,
  output logic             busy
);

  // Sample counter is wide enough to hold DEBOUNCE_CYCLES-1 with one spare bit.
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0]    CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [CNT_W-1:0] EVT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] EVT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CHECK = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   din_s;
  state_t                 state_r;
  state_t                 next_state_s;
  logic [CW-1:0]          cnt_r;
  logic [CW-1:0]          next_cnt_s;
  logic                   next_level_s;
  logic                   next_rise_s;
  logic                   next_fall_s;

  // The last synchronizer stage is the only view of din the FSM ever uses.
  assign din_s = sync_r[SYNC_STAGES-1];
  assign busy  = (state_r == CHECK);

  // Synchronizer chain; runs regardless of en so din_s is always current.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], din};
    end
  end

  // Next-state logic: qualify a candidate change, reject glitches, commit.
  always_comb begin
    next_state_s = state_r;
    next_cnt_s   = cnt_r;
    next_level_s = level;
    next_rise_s  = 1'b0;
    next_fall_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (en && (din_s != level)) begin
          next_cnt_s   = CNT_ONE;
          next_state_s = CHECK;
        end else begin
          next_cnt_s   = '0;
          next_state_s = IDLE;
        end
      end
      CHECK: begin
        if (!en) begin
          // Abort without a strobe; the candidate is simply forgotten.
          next_cnt_s   = '0;
          next_state_s = IDLE;
        end else if (din_s == level) begin
          // Input returned to the current level before qualifying: glitch.
          next_cnt_s   = '0;
          next_state_s = IDLE;
        end else if (cnt_r == CNT_LAST) begin
          next_level_s = din_s;
          next_rise_s  = din_s;
          next_fall_s  = ~din_s;
          next_cnt_s   = '0;
          next_state_s = IDLE;
        end else begin
          next_cnt_s   = cnt_r + CNT_ONE;
          next_state_s = CHECK;
        end
      end
      default: begin
        next_cnt_s   = '0;
        next_state_s = IDLE;
      end
    endcase
  end

  // FSM state, sample counter and registered level/strobe outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      level   <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      state_r <= next_state_s;
      cnt_r   <= next_cnt_s;
      level   <= next_level_s;
      rise    <= next_rise_s;
      fall    <= next_fall_s;
    end
  end

  // Saturating rising-edge counter; a clear on the commit edge takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      event_cnt <= '0;
    end else if (clr_cnt) begin
      event_cnt <= '0;
    end else if (next_rise_s && (event_cnt != EVT_MAX)) begin
      event_cnt <= event_cnt + EVT_ONE;
    end else begin
      event_cnt <= event_cnt;
    end
  end

endmodule

// File: tb/tb_debounce_edge.sv
// Testbench for debounce_edge (CNT_W=2 so saturation is reachable).
// Stimulus pushes expected strobe events into a scoreboard queue; a monitor
// pops and compares whenever the DUT emits rise or fall.
module tb_debounce_edge;

  logic       clk = 1'b0;
  logic       rst;
  logic       din;
  logic       en;
  logic       clr_cnt;
  logic       level;
  logic       rise;
  logic       fall;
  logic [1:0] event_cnt;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int exp_cnt = 0;

  typedef struct {
    bit         is_rise;
    bit         lvl;
    logic [1:0] cnt;
    int         cyc;
  } exp_t;

  exp_t sb_q[$];

  debounce_edge #(
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4),
    .CNT_W(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .din(din),
    .en(en),
    .clr_cnt(clr_cnt),
    .level(level),
    .rise(rise),
    .fall(fall),
    .event_cnt(event_cnt),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Free-running posedge counter used to timestamp expected commits.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Record an expected commit: strobe kind, cycle, resulting level and count.
  task automatic expect_edge(input bit is_rise, input int at, input bit clr);
    exp_t e;
    if (clr) exp_cnt = 0;
    else if (is_rise && exp_cnt != 3) exp_cnt = exp_cnt + 1;
    e.is_rise = is_rise;
    e.lvl     = is_rise;
    e.cnt     = 2'(exp_cnt);
    e.cyc     = at;
    sb_q.push_back(e);
  endtask

  task automatic drained(input string name);
    check(name, 32'(sb_q.size()), 32'd0);
  endtask

  task automatic wait_busy(input int limit);
    int n = 0;
    while (!busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("busy_seen", 32'(busy), 32'd1);
  endtask

  // Monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (rise || fall)) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: rise=%0b fall=%0b level=%0b at cycle %0d, none expected",
                 rise, fall, level, cyc);
      end else begin
        e = sb_q.pop_front();
        check("strobe_rise", 32'(rise), 32'(e.is_rise));
        check("strobe_fall", 32'(fall), 32'(!e.is_rise));
        check("commit_level", 32'(level), 32'(e.lvl));
        check("commit_event_cnt", 32'(event_cnt), 32'(e.cnt));
        check("commit_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int d;
    bit seen;
    int sat_exp[5];
    sat_exp = '{1, 2, 3, 3, 3};

    // Reset with din=1: all outputs 0.
    rst = 1'b1; din = 1'b1; en = 1'b1; clr_cnt = 1'b0;
    tick(3);
    check("rst_level", 32'(level), 32'd0);
    check("rst_rise", 32'(rise), 32'd0);
    check("rst_fall", 32'(fall), 32'd0);
    check("rst_event_cnt", 32'(event_cnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // Release: busy after 3rd posedge, rise after 6th.
    c = cyc;
    rst = 1'b0;
    expect_edge(1'b1, c + 6, 1'b0);
    tick(2);
    check("rel_busy_before", 32'(busy), 32'd0);
    tick(1);
    check("rel_busy_after3", 32'(busy), 32'd1);
    tick(8);
    check("rel_level", 32'(level), 32'd1);
    check("rel_event_cnt", 32'(event_cnt), 32'd1);
    drained("rel_drained");

    // Falling edge.
    c = cyc;
    din = 1'b0;
    expect_edge(1'b0, c + 6, 1'b0);
    tick(10);
    check("fall_level", 32'(level), 32'd0);
    check("fall_event_cnt", 32'(event_cnt), 32'd1);
    drained("fall_drained");

    // Glitch: 2-cycle pulse is rejected, busy pulses.
    seen = 1'b0;
    din = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick(1);
      if (busy) seen = 1'b1;
    end
    din = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (busy) seen = 1'b1;
    end
    check("glitch_busy_pulse", 32'(seen), 32'd1);
    check("glitch_level", 32'(level), 32'd0);
    check("glitch_event_cnt", 32'(event_cnt), 32'd1);
    check("glitch_busy_end", 32'(busy), 32'd0);
    drained("glitch_drained");

    // Enable abort, then re-enable commits DEBOUNCE_CYCLES edges later.
    din = 1'b1;
    wait_busy(10);
    tick(1);
    en = 1'b0;
    tick(1);
    check("abort_busy_drop", 32'(busy), 32'd0);
    tick(3);
    check("abort_level", 32'(level), 32'd0);
    check("abort_busy_idle", 32'(busy), 32'd0);
    drained("abort_drained");
    d = cyc;
    en = 1'b1;
    expect_edge(1'b1, d + 4, 1'b0);
    tick(8);
    check("reen_level", 32'(level), 32'd1);
    check("reen_event_cnt", 32'(event_cnt), 32'd2);
    drained("reen_drained");

    // Saturation with CNT_W=2: clear first, then 5 pulses.
    clr_cnt = 1'b1;
    tick(1);
    clr_cnt = 1'b0;
    exp_cnt = 0;
    check("clr_event_cnt", 32'(event_cnt), 32'd0);
    c = cyc;
    din = 1'b0;
    expect_edge(1'b0, c + 6, 1'b0);
    tick(10);
    for (int i = 0; i < 5; i++) begin
      c = cyc;
      din = 1'b1;
      expect_edge(1'b1, c + 6, 1'b0);
      tick(10);
      check("sat_event_cnt", 32'(event_cnt), 32'(sat_exp[i]));
      c = cyc;
      din = 1'b0;
      expect_edge(1'b0, c + 6, 1'b0);
      tick(10);
    end
    drained("sat_drained");

    // Clear on the same edge as a rise commit wins.
    c = cyc;
    din = 1'b1;
    expect_edge(1'b1, c + 6, 1'b1);
    tick(5);
    clr_cnt = 1'b1;
    tick(1);
    clr_cnt = 1'b0;
    tick(4);
    check("clrwin_event_cnt", 32'(event_cnt), 32'd0);
    check("clrwin_level", 32'(level), 32'd1);
    drained("clrwin_drained");

    // Reset in the middle of CHECK.
    c = cyc;
    din = 1'b0;
    expect_edge(1'b0, c + 6, 1'b0);
    tick(10);
    din = 1'b1;
    wait_busy(10);
    tick(1);
    rst = 1'b1;
    exp_cnt = 0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_level", 32'(level), 32'd0);
    check("midrst_rise", 32'(rise), 32'd0);
    check("midrst_fall", 32'(fall), 32'd0);
    check("midrst_cnt", 32'(dut.cnt_r), 32'd0);
    tick(2);
    check("midrst_busy_hold", 32'(busy), 32'd0);
    c = cyc;
    rst = 1'b0;
    expect_edge(1'b1, c + 6, 1'b0);
    tick(2);
    check("postrst_busy_before", 32'(busy), 32'd0);
    tick(1);
    check("postrst_busy_after3", 32'(busy), 32'd1);
    tick(8);
    check("postrst_level", 32'(level), 32'd1);
    check("postrst_event_cnt", 32'(event_cnt), 32'd1);
    drained("postrst_drained");

    // din toggling every cycle never commits.
    for (int i = 0; i < 20; i++) begin
      din = ~din;
      tick(1);
    end
    din = 1'b1;
    tick(8);
    check("toggle_level", 32'(level), 32'd1);
    check("toggle_event_cnt", 32'(event_cnt), 32'd1);
    drained("toggle_drained");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
